// File: rtl/median3_stream_ctrl.sv
// Streaming 3-tap median filter: a 3-deep sliding window feeds one shared
// min/max comparator that is sequenced over three compare steps per output.
module median3_stream_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_median,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, CMP1, CMP2, CMP3, OUT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] w0, w1, w2;
  logic [WIDTH-1:0] t1_min, t1_max, t2_min;
  logic [WIDTH-1:0] cmp_a, cmp_b, cmp_lo, cmp_hi;
  logic [1:0]       fill, fill_inc;
  logic             accept, deliver;

  // Equal operands return A on both outputs.
  function automatic logic [WIDTH-1:0] cmp_min(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return (b < a) ? b : a;
  endfunction

  function automatic logic [WIDTH-1:0] cmp_max(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return (b > a) ? b : a;
  endfunction

  assign in_ready  = (state == IDLE) && !clear;
  assign accept    = in_valid && in_ready;
  assign deliver   = (state == OUT) && out_ready && !clear;
  assign fill_inc  = (fill == 2'd3) ? 2'd3 : fill + 2'd1;
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign cmp_lo    = cmp_min(cmp_a, cmp_b);
  assign cmp_hi    = cmp_max(cmp_a, cmp_b);

  // median = max(min(w0,w1), min(max(w0,w1), w2))
  always_comb begin
    cmp_a = '0;
    cmp_b = '0;
    case (state)
      CMP1: begin cmp_a = w0;     cmp_b = w1;     end
      CMP2: begin cmp_a = t1_max; cmp_b = w2;     end
      CMP3: begin cmp_a = t1_min; cmp_b = t2_min; end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && fill_inc == 2'd3) state_nxt = CMP1;
        CMP1:    state_nxt = CMP2;
        CMP2:    state_nxt = CMP3;
        CMP3:    state_nxt = OUT;
        OUT:     if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fill       <= 2'd0;
      w0         <= '0;
      w1         <= '0;
      w2         <= '0;
      t1_min     <= '0;
      t1_max     <= '0;
      t2_min     <= '0;
      out_median <= '0;
      out_count  <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        fill      <= 2'd0;
        out_count <= '0;
      end else begin
        if (accept) begin
          w0   <= w1;
          w1   <= w2;
          w2   <= in_data;
          fill <= fill_inc;
        end
        if (state == CMP1) begin
          t1_min <= cmp_lo;
          t1_max <= cmp_hi;
        end
        if (state == CMP2) t2_min <= cmp_lo;
        if (state == CMP3) out_median <= cmp_hi;
        if (deliver) out_count <= out_count + CNT_W'(1);
      end
    end
  end

endmodule
